// File: rtl/vsfx_pkg.sv
// Shared definitions for the VSFX byte-lane datapaths: lane geometry, guarded
// operand width and the modulo/saturating mode encoding.
package vsfx_pkg;

  localparam int VSFX_LANES   = 4;
  localparam int VSFX_LANE_W  = 8;
  localparam int VSFX_GUARD_W = 36;

  typedef enum logic {
    VSFX_MOD = 1'b0,
    VSFX_SAT = 1'b1
  } vsfx_sat_mode_e;

  // Spread four bytes into 9-bit slots with a zero guard bit above each lane.
  function automatic logic [VSFX_GUARD_W-1:0] vsfx_guard(input logic [31:0] v);
    logic [VSFX_GUARD_W-1:0] g;
    g = {VSFX_GUARD_W{1'b0}};
    for (int i = 0; i < VSFX_LANES; i++) begin
      g[9*i +: 8] = v[8*i +: 8];
    end
    return g;
  endfunction

endpackage

// File: rtl/vsfx_vaddub_lane_sat.sv
// Combinational per-lane saturation mux: clamps a carried-out byte sum to 8'hFF
// in saturating mode and flags the clamp.
module vsfx_vaddub_lane_sat
  import vsfx_pkg::*;
(
  input  logic [VSFX_LANE_W:0]   i_sum,
  input  vsfx_sat_mode_e         i_mode,
  output logic [VSFX_LANE_W-1:0] o_res,
  output logic                   o_sat
);

  // Carry out of the lane is the guard bit; clamp only in saturating mode.
  always_comb begin
    o_sat = (i_mode == VSFX_SAT) && i_sum[VSFX_LANE_W];
    if (o_sat) begin
      o_res = {VSFX_LANE_W{1'b1}};
    end else begin
      o_res = i_sum[VSFX_LANE_W-1:0];
    end
  end

endmodule

// File: rtl/vsfx_vaddub_pipe.sv
// Two-stage vaddubm/vaddubs unit on one 32-bit slice with valid/ready on both sides.
// Saturating mode and the sticky VSCR[SAT] bit exist only with VSFX_VADDUBS_SAT_EN.
module vsfx_vaddub_pipe
  import vsfx_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sat,
  input  logic [31:0]      in_vra,
  input  logic [31:0]      in_vrb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_vrt,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_sat,
  output logic             vscr_sat,
  input  logic             sat_clr
);

  logic                    r_s1_v;
  logic                    r_s2_v;
  logic [VSFX_GUARD_W-1:0] r_s1_sum;
  logic [TAG_W-1:0]        r_s1_tag;
  logic [TAG_W-1:0]        r_s2_tag;
  logic [31:0]             r_s2_vrt;

  logic                    w_s1_load;
  logic                    w_s2_load;
  logic [VSFX_GUARD_W-1:0] w_sum;
  logic [31:0]             w_vrt;

  assign w_s2_load = r_s1_v && (!r_s2_v || out_ready);
  assign in_ready  = !r_s1_v || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  // Guard bits swallow each lane carry, so one wide add serves all four lanes.
  assign w_sum = vsfx_guard(in_vra) + vsfx_guard(in_vrb);

  // Stage valid flags: S1 refills on accept, S2 holds until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_s1_v <= w_s1_load || (r_s1_v && !w_s2_load);
      r_s2_v <= w_s2_load || (r_s2_v && !out_ready);
    end
  end

  // S1 data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sum <= {VSFX_GUARD_W{1'b0}};
      r_s1_tag <= {TAG_W{1'b0}};
    end else if (w_s1_load) begin
      r_s1_sum <= w_sum;
      r_s1_tag <= in_tag;
    end
  end

  // S2 data capture; held stable while the result waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vrt <= 32'h0000_0000;
      r_s2_tag <= {TAG_W{1'b0}};
    end else if (w_s2_load) begin
      r_s2_vrt <= w_vrt;
      r_s2_tag <= r_s1_tag;
    end
  end

  assign out_valid = r_s2_v;
  assign out_vrt   = r_s2_vrt;
  assign out_tag   = r_s2_tag;

`ifdef VSFX_VADDUBS_SAT_EN
  vsfx_sat_mode_e r_s1_mode;
  logic [3:0]     r_s2_sat;
  logic           r_vscr_sat;
  logic [3:0]     w_sat;

  // Mode travels with the guarded sum into S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_mode <= VSFX_MOD;
    end else if (w_s1_load) begin
      r_s1_mode <= in_sat ? VSFX_SAT : VSFX_MOD;
    end
  end

  for (genvar g = 0; g < VSFX_LANES; g++) begin : g_lane
    vsfx_vaddub_lane_sat u_lane_sat (
      .i_sum  (r_s1_sum[9*g +: 9]),
      .i_mode (r_s1_mode),
      .o_res  (w_vrt[8*g +: 8]),
      .o_sat  (w_sat[g])
    );
  end

  // Per-lane saturation flags ride alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_sat <= 4'b0000;
    end else if (w_s2_load) begin
      r_s2_sat <= w_sat;
    end
  end

  // Sticky SAT: set on S1->S2 move of a saturating result; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vscr_sat <= 1'b0;
    end else if (w_s2_load && (|w_sat)) begin
      r_vscr_sat <= 1'b1;
    end else if (sat_clr) begin
      r_vscr_sat <= 1'b0;
    end
  end

  assign out_sat  = r_s2_sat;
  assign vscr_sat = r_vscr_sat;
`else
  logic w_unused;

  for (genvar g = 0; g < VSFX_LANES; g++) begin : g_lane
    assign w_vrt[8*g +: 8] = r_s1_sum[9*g +: 8];
  end

  // Lane carries, mode and clear have no consumer in the modulo-only build.
  assign w_unused = ^{in_sat, sat_clr, r_s1_sum[35], r_s1_sum[26], r_s1_sum[17], r_s1_sum[8]};
  assign out_sat  = 4'b0000;
  assign vscr_sat = 1'b0;
`endif

endmodule

// File: tb/tb_vsfx_vaddub_pipe.sv
// Scoreboard bench for vsfx_vaddub_pipe: directed vectors push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_vsfx_vaddub_pipe;

  localparam int TAG_W = 4;
`ifdef VSFX_VADDUBS_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sat = 1'b0;
  logic [31:0]      in_vra = 32'h0;
  logic [31:0]      in_vrb = 32'h0;
  logic [TAG_W-1:0] in_tag = 4'h0;
  logic             out_ready = 1'b0;
  logic             sat_clr = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_vrt;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_sat;
  logic             vscr_sat;

  vsfx_vaddub_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sat(in_sat), .in_vra(in_vra), .in_vrb(in_vrb), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_vrt(out_vrt),
    .out_tag(out_tag), .out_sat(out_sat), .vscr_sat(vscr_sat), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] vrt;
    logic [3:0]  tag;
    logic [3:0]  sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t held;
  bit   held_v = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each transferred result against the scoreboard head,
  // and check that a stalled result does not change.
  always @(posedge clk) begin
    if (!rst_n) begin
      held_v <= 1'b0;
    end else begin
      if (held_v && out_valid) begin
        check32("stall_stable", {out_vrt, out_tag, out_sat}, {held.vrt, held.tag, held.sat});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check32("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          check32("out_vrt", out_vrt, sb_q[0].vrt);
          check32("out_tag", 32'(out_tag), 32'(sb_q[0].tag));
          check32("out_sat", 32'(out_sat), 32'(sb_q[0].sat));
          void'(sb_q.pop_front());
        end
        held_v <= 1'b0;
      end else if (out_valid) begin
        held_v <= 1'b1;
        held   <= '{vrt: out_vrt, tag: out_tag, sat: out_sat};
      end else begin
        held_v <= 1'b0;
      end
    end
  end

  // Present one op from a negedge, push its expectation once acceptance is certain.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] t, input logic [31:0] e_mod,
                       input logic [31:0] e_satv, input logic [3:0] e_bits);
    exp_t e;
    int   k;
    in_valid = 1'b1; in_vra = a; in_vrb = b; in_sat = s; in_tag = t;
    e.tag = t;
    if (SAT_EN && s) begin
      e.vrt = e_satv; e.sat = e_bits;
    end else begin
      e.vrt = e_mod;  e.sat = 4'b0000;
    end
    for (k = 0; k < 60; k++) begin
      #1;
      if (in_ready) break;
      @(negedge clk);
    end
    if (k == 60) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: tag %0d not accepted in 60 cycles", t);
    end else begin
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
    check32("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    // Reset with in_valid asserted: nothing may be taken.
    in_valid = 1'b1; in_vra = 32'hFF01807F; in_vrb = 32'h01FF8001; in_tag = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check32("rst_in_ready", 32'(in_ready), 32'd1);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_out_vrt", out_vrt, 32'h0);
    check32("rst_out_tag", 32'(out_tag), 32'd0);
    check32("rst_out_sat", 32'(out_sat), 32'd0);
    check32("rst_vscr_sat", 32'(vscr_sat), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check32("no_accept_in_reset", 32'(out_valid), 32'd0);

    // Modulo with latency probe.
    @(negedge clk);
    issue(32'hFF01807F, 32'h01FF8001, 1'b0, 4'd1, 32'h00000080, 32'h00000080, 4'b0000);
    #1 check32("lat_edge_n", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check32("lat_edge_n1_valid", 32'(out_valid), 32'd1);
    check32("lat_edge_n1_vrt", out_vrt, 32'h00000080);
    check32("mod_vscr", 32'(vscr_sat), 32'd0);

    // Saturating on the same operands.
    @(negedge clk);
    issue(32'hFF01807F, 32'h01FF8001, 1'b1, 4'd2, 32'h00000080, 32'hFFFFFF80, 4'b1110);
    repeat (2) @(negedge clk);
    #1 check32("sat_vscr", 32'(vscr_sat), 32'(SAT_EN));

    // Back-to-back stream with out_ready high.
    @(negedge clk);
    issue(32'h00000000, 32'h00000000, 1'b0, 4'd3, 32'h00000000, 32'h00000000, 4'b0000);
    issue(32'h12345678, 32'h11111111, 1'b1, 4'd4, 32'h23456789, 32'h23456789, 4'b0000);
    issue(32'hFFFFFFFF, 32'h01010101, 1'b0, 4'd5, 32'h00000000, 32'hFFFFFFFF, 4'b1111);
    issue(32'hFEFFFF01, 32'h01000102, 1'b1, 4'd6, 32'hFFFF0003, 32'hFFFFFF03, 4'b0010);
    drain();

    // Sticky flag: clear, then set and clear collide, then clear alone.
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    #1 check32("sticky_pre_clear", 32'(vscr_sat), 32'd0);
    @(negedge clk);
    issue(32'h80000000, 32'h80000000, 1'b1, 4'd7, 32'h00000000, 32'hFF000000, 4'b1000);
    sat_clr = 1'b1;
    @(negedge clk);
    #1 check32("sticky_set_wins", 32'(vscr_sat), 32'(SAT_EN));
    @(negedge clk);
    #1 check32("sticky_clr", 32'(vscr_sat), 32'd0);
    sat_clr = 1'b0;
    drain();

    // Backpressure: two accepted with out_ready low, then in_ready must drop.
    @(negedge clk); out_ready = 1'b0;
    issue(32'hFF01807F, 32'h01FF8001, 1'b0, 4'd0, 32'h00000080, 32'h00000080, 4'b0000);
    issue(32'hFF01807F, 32'h01FF8001, 1'b1, 4'd1, 32'h00000080, 32'hFFFFFF80, 4'b1110);
    in_valid = 1'b1; in_vra = 32'h12345678; in_vrb = 32'h11111111; in_sat = 1'b0; in_tag = 4'd2;
    for (int k = 0; k < 3; k++) begin
      #1 check32("full_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check32("passthru_in_ready", 32'(in_ready), 32'd1);
    issue(32'h12345678, 32'h11111111, 1'b0, 4'd2, 32'h23456789, 32'h23456789, 4'b0000);
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
      begin
        issue(32'hFFFFFFFF, 32'h01010101, 1'b1, 4'd3, 32'h00000000, 32'hFFFFFFFF, 4'b1111);
        issue(32'h7F7F7F7F, 32'h01010101, 1'b1, 4'd4, 32'h80808080, 32'h80808080, 4'b0000);
        issue(32'hFEFFFF01, 32'h01000102, 1'b0, 4'd5, 32'hFFFF0003, 32'hFFFFFF03, 4'b0010);
      end
    join
    out_ready = 1'b1;
    drain();
    #1 check32("bp_vscr", 32'(vscr_sat), 32'(SAT_EN));

    // Reset mid-flight: both in-flight ops vanish.
    @(negedge clk); out_ready = 1'b0;
    issue(32'h12345678, 32'h11111111, 1'b0, 4'd8, 32'h23456789, 32'h23456789, 4'b0000);
    issue(32'h7F7F7F7F, 32'h01010101, 1'b0, 4'd9, 32'h80808080, 32'h80808080, 4'b0000);
    rst_n = 1'b0;
    #1 check32("midrst_out_valid", 32'(out_valid), 32'd0);
    check32("midrst_in_ready", 32'(in_ready), 32'd1);
    check32("midrst_vscr", 32'(vscr_sat), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check32("midrst_no_stale", 32'(out_valid), 32'd0);
    @(negedge clk);
    issue(32'h01020304, 32'h10203040, 1'b0, 4'd10, 32'h11223344, 32'h11223344, 4'b0000);
    #1 check32("postrst_lat_n", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check32("postrst_lat_n1", 32'(out_valid), 32'd1);
    check32("postrst_vrt", out_vrt, 32'h11223344);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
